// File: rtl/matrix_multiply_pkg.sv
// Shared constants and helpers for the matrix_multiply MAC datapath.
// Saturation limits are returned at MAC_SAT_W bits; callers truncate to their own width.
package matrix_multiply_pkg;

  localparam int MAC_MAX_STAGE = 8;
  localparam int MAC_SAT_W     = 128;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic [MAC_SAT_W-1:0] sat_max(input int width, input logic is_signed);
    logic [MAC_SAT_W-1:0] one;
    one = MAC_SAT_W'(1);
    return is_signed ? (one << (width - 1)) - one : (one << width) - one;
  endfunction

  function automatic logic [MAC_SAT_W-1:0] sat_min(input int width, input logic is_signed);
    logic [MAC_SAT_W-1:0] one;
    one = MAC_SAT_W'(1);
    return is_signed ? ~((one << (width - 1)) - one) : '0;
  endfunction

endpackage

// File: rtl/matrix_multiply_mul_pipe.sv
// Enable-gated multiplier pipeline: full-width product plus valid/last/signed sideband,
// shifted through NUM_STAGE registers. Everything holds while en is low.
module matrix_multiply_mul_pipe
  import matrix_multiply_pkg::*;
#(
  parameter int NUM_STAGE = 3,
  parameter int A_W       = 32,
  parameter int B_W       = 32,
  localparam int P_W      = prod_width(A_W, B_W)
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           en,
  input  logic           beat_valid,
  input  logic           beat_last,
  input  logic           beat_signed,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           prod_valid,
  output logic           prod_last,
  output logic           prod_signed,
  output logic [P_W-1:0] prod
);

  if (NUM_STAGE < 1 || NUM_STAGE > MAC_MAX_STAGE) begin : g_bad_stage
    $error("matrix_multiply_mul_pipe: NUM_STAGE out of range");
  end

  logic [P_W-1:0]       a_ext, b_ext, prod_c;
  logic [P_W-1:0]       prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] valid_q, last_q, signed_q;

  // Extending both operands to the product width makes one unsigned multiply exact for either mode.
  always_comb begin
    a_ext  = {{B_W{a[A_W-1] & beat_signed}}, a};
    b_ext  = {{A_W{b[B_W-1] & beat_signed}}, b};
    prod_c = a_ext * b_ext;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q  <= '0;
      last_q   <= '0;
      signed_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
    end else if (en) begin
      valid_q[0]  <= beat_valid;
      last_q[0]   <= beat_last;
      signed_q[0] <= beat_signed;
      prod_q[0]   <= prod_c;
      for (int i = 1; i < NUM_STAGE; i++) begin
        valid_q[i]  <= valid_q[i-1];
        last_q[i]   <= last_q[i-1];
        signed_q[i] <= signed_q[i-1];
        prod_q[i]   <= prod_q[i-1];
      end
    end
  end

  assign prod_valid  = valid_q[NUM_STAGE-1];
  assign prod_last   = last_q[NUM_STAGE-1];
  assign prod_signed = signed_q[NUM_STAGE-1];
  assign prod        = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/matrix_multiply_mac_pipe.sv
// Pipelined multiply-accumulate engine: one dot-product per in_last-delimited vector.
// Optional MATRIX_MULTIPLY_MAC_SAT_EN: saturating accumulate plus sticky sat_flag output.
module matrix_multiply_mac_pipe
  import matrix_multiply_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 48
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  in_signed,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef MATRIX_MULTIPLY_MAC_SAT_EN
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag
`else
  output logic [dout_WIDTH-1:0] dout
`endif
);

  localparam int P_W       = prod_width(din0_WIDTH, din1_WIDTH);
  // One guard bit above the wider of product and accumulator keeps the raw sum exact.
  localparam int E_W       = ((P_W > dout_WIDTH) ? P_W : dout_WIDTH) + 1;
  localparam int unused_id = ID;

  logic                  en;
  logic                  m_valid, m_last, m_signed;
  logic [P_W-1:0]        m_prod;
  logic [dout_WIDTH-1:0] acc, sum;
  logic                  first;
  logic [E_W-1:0]        acc_e, prod_e, sum_e;

  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  matrix_multiply_mul_pipe #(
    .NUM_STAGE (NUM_STAGE),
    .A_W       (din0_WIDTH),
    .B_W       (din1_WIDTH)
  ) u_mul (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .en          (en),
    .beat_valid  (in_valid & in_ready),
    .beat_last   (in_last),
    .beat_signed (in_signed),
    .a           (din0),
    .b           (din1),
    .prod_valid  (m_valid),
    .prod_last   (m_last),
    .prod_signed (m_signed),
    .prod        (m_prod)
  );

`ifdef MATRIX_MULTIPLY_MAC_SAT_EN
  logic                  sat_lock, sat_hit;
  logic [dout_WIDTH-1:0] lim_hi, lim_lo;

  always_comb begin
    acc_e   = first ? '0 : (m_signed ? {{(E_W-dout_WIDTH){acc[dout_WIDTH-1]}}, acc}
                                     : {{(E_W-dout_WIDTH){1'b0}}, acc});
    prod_e  = {{(E_W-P_W){m_signed & m_prod[P_W-1]}}, m_prod};
    sum_e   = acc_e + prod_e;
    sum     = sum_e[dout_WIDTH-1:0];
    lim_hi  = dout_WIDTH'(sat_max(dout_WIDTH, m_signed));
    lim_lo  = dout_WIDTH'(sat_min(dout_WIDTH, m_signed));
    sat_hit = 1'b0;
    // A vector that has clamped keeps the clamp value until its last beat.
    if (sat_lock) begin
      sum = acc;
    end else if (m_signed &&
                 (sum_e[E_W-1:dout_WIDTH-1] != {(E_W-dout_WIDTH+1){sum_e[E_W-1]}})) begin
      sat_hit = 1'b1;
      sum     = sum_e[E_W-1] ? lim_lo : lim_hi;
    end else if (!m_signed && (sum_e[E_W-1:dout_WIDTH] != '0)) begin
      sat_hit = 1'b1;
      sum     = lim_hi;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_lock <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (en && m_valid) sat_lock <= ~m_last & (sat_lock | sat_hit);
      if (en && m_valid && sat_hit) sat_flag <= 1'b1;
      else if (out_valid && out_ready) sat_flag <= 1'b0;
    end
  end
`else
  logic unused_sum_hi;

  always_comb begin
    acc_e  = first ? '0 : (m_signed ? {{(E_W-dout_WIDTH){acc[dout_WIDTH-1]}}, acc}
                                    : {{(E_W-dout_WIDTH){1'b0}}, acc});
    prod_e = {{(E_W-P_W){m_signed & m_prod[P_W-1]}}, m_prod};
    sum_e  = acc_e + prod_e;
    sum    = sum_e[dout_WIDTH-1:0];
  end

  assign unused_sum_hi = ^sum_e[E_W-1:dout_WIDTH];
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (en) begin
      out_valid <= m_valid & m_last;
      if (m_valid) begin
        if (m_last) begin
          dout  <= sum;
          acc   <= '0;
          first <= 1'b1;
        end else begin
          acc   <= sum;
          first <= 1'b0;
        end
      end
    end
  end

endmodule
